serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 15 +
 rtl/serial_subtractor.sv | 64 ++++++
 tb/tb_serial_subtractor.sv | 129 ++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: request/result bundle for the bit-serial subtractor.
//   start, A, B                       : requester -> subtractor
//   diff, borrow, overflow, busy, done: subtractor -> requester
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             busy;
  logic             done;
  modport master (output start, A, B, input diff, borrow, overflow, busy, done);
  modport slave  (input start, A, B, output diff, borrow, overflow, busy, done);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial A-B, one bit per clock, WIDTH+2 cycles per result.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of serial_subtractor_if (start/A/B in; diff/borrow/overflow/busy/done out)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_bin, r_borrow, r_ovf;
  logic             w_d, w_bout, w_last;
  assign w_d    = r_a[0] ^ r_b[0] ^ r_bin;
  assign w_bout = (~r_a[0] & r_b[0]) | (~r_a[0] & r_bin) | (r_b[0] & r_bin);
  assign w_last = r_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && bus.start) ? RUN  :
             (r_state == RUN  && w_last)    ? DONE :
             (r_state == DONE)              ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_bin    <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == IDLE && bus.start) begin
      r_a   <= bus.A;
      r_b   <= bus.B;
      r_cnt <= '0;
      r_bin <= 1'b0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= {w_d, r_res[WIDTH-1:1]};
      r_cnt <= r_cnt + 1'b1;
      r_bin <= w_bout;
      if (w_last) begin
        // On the last bit r_a[0]/r_b[0] hold the original sign bits.
        r_diff   <= {w_d, r_res[WIDTH-1:1]};
        r_borrow <= w_bout;
        r_ovf    <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
      end
    end
  end
  assign bus.diff     = r_diff;
  assign bus.borrow   = r_borrow;
  assign bus.overflow = r_ovf;
  assign bus.busy     = r_state == RUN;
  assign bus.done     = r_state == DONE;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors with a result scoreboard for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
  typedef struct packed {logic [7:0] d; logic b; logic o;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t m_e;
  serial_subtractor_if #(.WIDTH(8)) bus();
  serial_subtractor #(.WIDTH(8)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    check("busy_and_done", {31'b0, bus.busy & bus.done}, 32'd0);
    if (bus.done) begin
      if (q.size() == 0) check("done_with_empty_queue", q.size(), 32'd1);
      else begin
        m_e = q.pop_front();
        check("diff", {24'b0, bus.diff}, {24'b0, m_e.d});
        check("borrow", {31'b0, bus.borrow}, {31'b0, m_e.b});
        check("overflow", {31'b0, bus.overflow}, {31'b0, m_e.o});
      end
    end
  end
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input exp_t e, input bit repulse);
    int cyc = 0;
    int bcnt = 0;
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = 8'h55;
    bus.B = 8'hAA;
    while (!bus.done && cyc < 20) begin
      bcnt += int'(bus.busy);
      if (repulse && cyc == 2) begin
        bus.start = 1'b1;
        bus.A = 8'd1;
        bus.B = 8'd1;
      end else if (repulse && cyc == 3) bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, 32'd8);
    check("busy_cycles", bcnt, 32'd8);
    @(negedge clk);
    check("done_single_pulse", {31'b0, bus.done}, 32'd0);
    check("hold_diff", {24'b0, bus.diff}, {24'b0, e.d});
  endtask
  initial begin
    int cyc;
    bus.start = 1'b1;
    bus.A = 8'd3;
    bus.B = 8'd1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    check("rst_diff", {24'b0, bus.diff}, 32'd0);
    check("rst_borrow", {31'b0, bus.borrow}, 32'd0);
    check("rst_overflow", {31'b0, bus.overflow}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    check("rst_dominates_start", {31'b0, bus.busy}, 32'd0);
    run_op(8'd100, 8'd37, '{8'd63, 1'b0, 1'b0}, 1'b0);
    run_op(8'd37, 8'd100, '{8'hC1, 1'b1, 1'b0}, 1'b0);
    run_op(8'h80, 8'h01, '{8'h7F, 1'b0, 1'b1}, 1'b0);
    run_op(8'h7F, 8'hFF, '{8'h80, 1'b1, 1'b1}, 1'b0);
    run_op(8'h00, 8'h00, '{8'h00, 1'b0, 1'b0}, 1'b0);
    run_op(8'hFF, 8'hFF, '{8'h00, 1'b0, 1'b0}, 1'b0);
    run_op(8'd100, 8'd37, '{8'd63, 1'b0, 1'b0}, 1'b1);
    // Abort: reset lands on the 4th RUN edge.
    @(negedge clk);
    bus.A = 8'd100;
    bus.B = 8'd37;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_diff", {24'b0, bus.diff}, 32'd0);
    check("abort_borrow", {31'b0, bus.borrow}, 32'd0);
    check("abort_overflow", {31'b0, bus.overflow}, 32'd0);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    repeat (12) @(negedge clk);
    run_op(8'd5, 8'd9, '{8'hFC, 1'b1, 1'b0}, 1'b0);
    // Back-to-back with start held high.
    @(negedge clk);
    bus.A = 8'h10;
    bus.B = 8'h20;
    bus.start = 1'b1;
    q.push_back('{8'hF0, 1'b1, 1'b0});
    q.push_back('{8'h4B, 1'b0, 1'b0});
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_first_latency", cyc, 32'd9);
    bus.A = 8'h50;
    bus.B = 8'h05;
    cyc = 0;
    @(negedge clk);
    cyc++;
    while (!bus.done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_period", cyc, 32'd10);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_idle_busy", {31'b0, bus.busy}, 32'd0);
    check("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
